// File: rtl/pipe_pkg.sv
// Shared widths and bank layouts for the MIPS inter-stage registers.
// Each bank is a packed struct so one generic register can hold it whole.
package pipe_pkg;

  localparam int WORD_W  = 32;
  localparam int REG_W   = 5;
  localparam int IMM_W   = 16;
  localparam int ALUOP_W = 2;

  // Decode control carried into EX; all-zero is a bubble.
  typedef struct packed {
    logic               regWrite;
    logic               memToReg;
    logic               memRead;
    logic               memWrite;
    logic               regDst;
    logic               aluSrc;
    logic               branch;
    logic [ALUOP_W-1:0] aluOp;
  } idexCtrl_t;

  typedef struct packed {
    logic regWrite;
    logic memToReg;
    logic memRead;
    logic memWrite;
  } exmemCtrl_t;

  typedef struct packed {
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] pc4;
  } ifidBank_t;

  typedef struct packed {
    idexCtrl_t         ctrl;
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] readData1;
    logic [WORD_W-1:0] readData2;
    logic [IMM_W-1:0]  immediate;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } idexBank_t;

  typedef struct packed {
    exmemCtrl_t        ctrl;
    logic [WORD_W-1:0] aluResult;
    logic [WORD_W-1:0] writeData;
    logic [REG_W-1:0]  destReg;
  } exmemBank_t;

endpackage

// File: rtl/pipeline_stage_regs_if.sv
// Stage-side signals of the inter-stage register banks.
// The pipeline core drives through master; the register block uses slave.
interface pipeline_stage_regs_if;
  import pipe_pkg::*;

  logic [WORD_W-1:0]  if_instruction;
  logic [WORD_W-1:0]  if_pc4;
  logic               ifid_hold;
  logic [WORD_W-1:0]  ifid_instruction;
  logic [WORD_W-1:0]  ifid_pc4;

  logic               id_reg_write;
  logic               id_mem_to_reg;
  logic               id_mem_read;
  logic               id_mem_write;
  logic               id_reg_dst;
  logic               id_alu_src;
  logic               id_branch;
  logic [ALUOP_W-1:0] id_alu_op;
  logic [WORD_W-1:0]  id_pc4;
  logic [WORD_W-1:0]  id_read_data1;
  logic [WORD_W-1:0]  id_read_data2;
  logic [IMM_W-1:0]   id_immediate;
  logic [REG_W-1:0]   id_rs;
  logic [REG_W-1:0]   id_rt;
  logic [REG_W-1:0]   id_rd;

  logic               idex_reg_write;
  logic               idex_mem_to_reg;
  logic               idex_mem_read;
  logic               idex_mem_write;
  logic               idex_reg_dst;
  logic               idex_alu_src;
  logic               idex_branch;
  logic [ALUOP_W-1:0] idex_alu_op;
  logic [WORD_W-1:0]  idex_pc4;
  logic [WORD_W-1:0]  idex_read_data1;
  logic [WORD_W-1:0]  idex_read_data2;
  logic [IMM_W-1:0]   idex_immediate;
  logic [REG_W-1:0]   idex_rs;
  logic [REG_W-1:0]   idex_rt;
  logic [REG_W-1:0]   idex_rd;

  logic               ex_reg_write;
  logic               ex_mem_to_reg;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic [WORD_W-1:0]  ex_alu_result;
  logic [WORD_W-1:0]  ex_write_data;
  logic [REG_W-1:0]   ex_dest_reg;

  logic               exmem_reg_write;
  logic               exmem_mem_to_reg;
  logic               exmem_mem_read;
  logic               exmem_mem_write;
  logic [WORD_W-1:0]  exmem_alu_result;
  logic [WORD_W-1:0]  exmem_write_data;
  logic [REG_W-1:0]   exmem_dest_reg;

  modport master (
    output if_instruction, if_pc4, ifid_hold,
    output id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
    output id_reg_dst, id_alu_src, id_branch, id_alu_op,
    output id_pc4, id_read_data1, id_read_data2, id_immediate,
    output id_rs, id_rt, id_rd,
    output ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
    output ex_alu_result, ex_write_data, ex_dest_reg,
    input  ifid_instruction, ifid_pc4,
    input  idex_reg_write, idex_mem_to_reg, idex_mem_read, idex_mem_write,
    input  idex_reg_dst, idex_alu_src, idex_branch, idex_alu_op,
    input  idex_pc4, idex_read_data1, idex_read_data2, idex_immediate,
    input  idex_rs, idex_rt, idex_rd,
    input  exmem_reg_write, exmem_mem_to_reg, exmem_mem_read, exmem_mem_write,
    input  exmem_alu_result, exmem_write_data, exmem_dest_reg
  );

  modport slave (
    input  if_instruction, if_pc4, ifid_hold,
    input  id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
    input  id_reg_dst, id_alu_src, id_branch, id_alu_op,
    input  id_pc4, id_read_data1, id_read_data2, id_immediate,
    input  id_rs, id_rt, id_rd,
    input  ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
    input  ex_alu_result, ex_write_data, ex_dest_reg,
    output ifid_instruction, ifid_pc4,
    output idex_reg_write, idex_mem_to_reg, idex_mem_read, idex_mem_write,
    output idex_reg_dst, idex_alu_src, idex_branch, idex_alu_op,
    output idex_pc4, idex_read_data1, idex_read_data2, idex_immediate,
    output idex_rs, idex_rt, idex_rd,
    output exmem_reg_write, exmem_mem_to_reg, exmem_mem_read, exmem_mem_write,
    output exmem_alu_result, exmem_write_data, exmem_dest_reg
  );

endinterface

// File: rtl/pipe_reg.sv
// Generic W-bit pipeline register: synchronous clear, load unless held.
module pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every bank samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_stage_regs.sv
// IF/ID, ID/EX and EX/MEM register banks of the 5-stage MIPS pipeline.
// Only IF/ID can be held; bubbles arrive as zeroed id_* control.
module pipeline_stage_regs
  import pipe_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  pipeline_stage_regs_if.slave bus
);

  ifidBank_t  ifidD,  ifidQ;
  idexBank_t  idexD,  idexQ;
  exmemBank_t exmemD, exmemQ;

  assign ifidD.instruction = bus.if_instruction;
  assign ifidD.pc4         = bus.if_pc4;

  assign idexD.ctrl.regWrite = bus.id_reg_write;
  assign idexD.ctrl.memToReg = bus.id_mem_to_reg;
  assign idexD.ctrl.memRead  = bus.id_mem_read;
  assign idexD.ctrl.memWrite = bus.id_mem_write;
  assign idexD.ctrl.regDst   = bus.id_reg_dst;
  assign idexD.ctrl.aluSrc   = bus.id_alu_src;
  assign idexD.ctrl.branch   = bus.id_branch;
  assign idexD.ctrl.aluOp    = bus.id_alu_op;
  assign idexD.pc4           = bus.id_pc4;
  assign idexD.readData1     = bus.id_read_data1;
  assign idexD.readData2     = bus.id_read_data2;
  assign idexD.immediate     = bus.id_immediate;
  assign idexD.rs            = bus.id_rs;
  assign idexD.rt            = bus.id_rt;
  assign idexD.rd            = bus.id_rd;

  assign exmemD.ctrl.regWrite = bus.ex_reg_write;
  assign exmemD.ctrl.memToReg = bus.ex_mem_to_reg;
  assign exmemD.ctrl.memRead  = bus.ex_mem_read;
  assign exmemD.ctrl.memWrite = bus.ex_mem_write;
  assign exmemD.aluResult     = bus.ex_alu_result;
  assign exmemD.writeData     = bus.ex_write_data;
  assign exmemD.destReg       = bus.ex_dest_reg;

  pipe_reg #(.W($bits(ifidBank_t))) ifidReg (
    .clk   (clk),
    .reset (reset),
    .hold  (bus.ifid_hold),
    .d     (ifidD),
    .q     (ifidQ)
  );

  pipe_reg #(.W($bits(idexBank_t))) idexReg (
    .clk   (clk),
    .reset (reset),
    .hold  (1'b0),
    .d     (idexD),
    .q     (idexQ)
  );

  pipe_reg #(.W($bits(exmemBank_t))) exmemReg (
    .clk   (clk),
    .reset (reset),
    .hold  (1'b0),
    .d     (exmemD),
    .q     (exmemQ)
  );

  assign bus.ifid_instruction = ifidQ.instruction;
  assign bus.ifid_pc4         = ifidQ.pc4;

  assign bus.idex_reg_write  = idexQ.ctrl.regWrite;
  assign bus.idex_mem_to_reg = idexQ.ctrl.memToReg;
  assign bus.idex_mem_read   = idexQ.ctrl.memRead;
  assign bus.idex_mem_write  = idexQ.ctrl.memWrite;
  assign bus.idex_reg_dst    = idexQ.ctrl.regDst;
  assign bus.idex_alu_src    = idexQ.ctrl.aluSrc;
  assign bus.idex_branch     = idexQ.ctrl.branch;
  assign bus.idex_alu_op     = idexQ.ctrl.aluOp;
  assign bus.idex_pc4        = idexQ.pc4;
  assign bus.idex_read_data1 = idexQ.readData1;
  assign bus.idex_read_data2 = idexQ.readData2;
  assign bus.idex_immediate  = idexQ.immediate;
  assign bus.idex_rs         = idexQ.rs;
  assign bus.idex_rt         = idexQ.rt;
  assign bus.idex_rd         = idexQ.rd;

  assign bus.exmem_reg_write  = exmemQ.ctrl.regWrite;
  assign bus.exmem_mem_to_reg = exmemQ.ctrl.memToReg;
  assign bus.exmem_mem_read   = exmemQ.ctrl.memRead;
  assign bus.exmem_mem_write  = exmemQ.ctrl.memWrite;
  assign bus.exmem_alu_result = exmemQ.aluResult;
  assign bus.exmem_write_data = exmemQ.writeData;
  assign bus.exmem_dest_reg   = exmemQ.destReg;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Directed self-checking bench for the inter-stage register banks.
module tb_pipeline_stage_regs;
  import pipe_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipeline_stage_regs_if bus ();

  pipeline_stage_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Inputs change just after a rising edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic v);
    bus.if_instruction = {WORD_W{v}};
    bus.if_pc4         = {WORD_W{v}};
    bus.ifid_hold      = v;
    bus.id_reg_write   = v;
    bus.id_mem_to_reg  = v;
    bus.id_mem_read    = v;
    bus.id_mem_write   = v;
    bus.id_reg_dst     = v;
    bus.id_alu_src     = v;
    bus.id_branch      = v;
    bus.id_alu_op      = {ALUOP_W{v}};
    bus.id_pc4         = {WORD_W{v}};
    bus.id_read_data1  = {WORD_W{v}};
    bus.id_read_data2  = {WORD_W{v}};
    bus.id_immediate   = {IMM_W{v}};
    bus.id_rs          = {REG_W{v}};
    bus.id_rt          = {REG_W{v}};
    bus.id_rd          = {REG_W{v}};
    bus.ex_reg_write   = v;
    bus.ex_mem_to_reg  = v;
    bus.ex_mem_read    = v;
    bus.ex_mem_write   = v;
    bus.ex_alu_result  = {WORD_W{v}};
    bus.ex_write_data  = {WORD_W{v}};
    bus.ex_dest_reg    = {REG_W{v}};
  endtask

  task automatic check_exmem_zero(input string tag);
    check({tag, " exmem_reg_write"},  32'(bus.exmem_reg_write),  32'd0);
    check({tag, " exmem_mem_to_reg"}, 32'(bus.exmem_mem_to_reg), 32'd0);
    check({tag, " exmem_mem_read"},   32'(bus.exmem_mem_read),   32'd0);
    check({tag, " exmem_mem_write"},  32'(bus.exmem_mem_write),  32'd0);
    check({tag, " exmem_alu_result"}, bus.exmem_alu_result,      32'd0);
    check({tag, " exmem_write_data"}, bus.exmem_write_data,      32'd0);
    check({tag, " exmem_dest_reg"},   32'(bus.exmem_dest_reg),   32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with every input at all-ones, hold included.
    drive_all(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst ifid_instruction", bus.ifid_instruction, 32'd0);
    check("rst ifid_pc4",         bus.ifid_pc4,         32'd0);
    check("rst idex_reg_write",   32'(bus.idex_reg_write),  32'd0);
    check("rst idex_mem_to_reg",  32'(bus.idex_mem_to_reg), 32'd0);
    check("rst idex_mem_read",    32'(bus.idex_mem_read),   32'd0);
    check("rst idex_mem_write",   32'(bus.idex_mem_write),  32'd0);
    check("rst idex_reg_dst",     32'(bus.idex_reg_dst),    32'd0);
    check("rst idex_alu_src",     32'(bus.idex_alu_src),    32'd0);
    check("rst idex_branch",      32'(bus.idex_branch),     32'd0);
    check("rst idex_alu_op",      32'(bus.idex_alu_op),     32'd0);
    check("rst idex_pc4",         bus.idex_pc4,             32'd0);
    check("rst idex_read_data1",  bus.idex_read_data1,      32'd0);
    check("rst idex_read_data2",  bus.idex_read_data2,      32'd0);
    check("rst idex_immediate",   32'(bus.idex_immediate),  32'd0);
    check("rst idex_rs",          32'(bus.idex_rs),         32'd0);
    check("rst idex_rt",          32'(bus.idex_rt),         32'd0);
    check("rst idex_rd",          32'(bus.idex_rd),         32'd0);
    check_exmem_zero("rst");

    // Quiet the ID/EX and EX/MEM inputs before the directed vectors.
    drive_all(1'b0);

    // IF/ID flow.
    bus.if_instruction = 32'h8C43_0004;
    bus.if_pc4         = 32'h0000_0010;
    bus.ifid_hold      = 1'b0;
    tick();
    check("flow ifid_instruction", bus.ifid_instruction, 32'h8C43_0004);
    check("flow ifid_pc4",         bus.ifid_pc4,         32'h0000_0010);

    // Stall for two edges, then release.
    bus.if_instruction = 32'h00A6_3020;
    bus.if_pc4         = 32'h0000_0014;
    bus.ifid_hold      = 1'b1;
    tick();
    check("stall1 ifid_instruction", bus.ifid_instruction, 32'h8C43_0004);
    check("stall1 ifid_pc4",         bus.ifid_pc4,         32'h0000_0010);
    tick();
    check("stall2 ifid_instruction", bus.ifid_instruction, 32'h8C43_0004);
    bus.ifid_hold = 1'b0;
    tick();
    check("release ifid_instruction", bus.ifid_instruction, 32'h00A6_3020);
    check("release ifid_pc4",         bus.ifid_pc4,         32'h0000_0014);

    // ID/EX load.
    bus.id_reg_write  = 1'b1;
    bus.id_alu_op     = 2'b10;
    bus.id_alu_src    = 1'b1;
    bus.id_pc4        = 32'h0000_0018;
    bus.id_read_data1 = 32'd30;
    bus.id_read_data2 = 32'd40;
    bus.id_immediate  = 16'h0004;
    bus.id_rs         = 5'd3;
    bus.id_rt         = 5'd4;
    bus.id_rd         = 5'd5;
    tick();
    check("idex reg_write",  32'(bus.idex_reg_write),  32'd1);
    check("idex mem_read",   32'(bus.idex_mem_read),   32'd0);
    check("idex alu_src",    32'(bus.idex_alu_src),    32'd1);
    check("idex alu_op",     32'(bus.idex_alu_op),     32'd2);
    check("idex pc4",        bus.idex_pc4,             32'h0000_0018);
    check("idex read_data1", bus.idex_read_data1,      32'd30);
    check("idex read_data2", bus.idex_read_data2,      32'd40);
    check("idex immediate",  32'(bus.idex_immediate),  32'h0004);
    check("idex rs",         32'(bus.idex_rs),         32'd3);
    check("idex rt",         32'(bus.idex_rt),         32'd4);
    check("idex rd",         32'(bus.idex_rd),         32'd5);

    // Bubble: control zeroed, data still flows.
    bus.id_reg_write  = 1'b0;
    bus.id_alu_op     = 2'b00;
    bus.id_alu_src    = 1'b0;
    bus.id_read_data1 = 32'd31;
    bus.id_rd         = 5'd7;
    tick();
    check("bubble reg_write",  32'(bus.idex_reg_write), 32'd0);
    check("bubble alu_op",     32'(bus.idex_alu_op),    32'd0);
    check("bubble read_data1", bus.idex_read_data1,     32'd31);
    check("bubble rd",         32'(bus.idex_rd),        32'd7);

    // EX/MEM loads while IF/ID is held.
    bus.ifid_hold     = 1'b1;
    bus.if_instruction = 32'h1234_5678;
    bus.ex_mem_write  = 1'b1;
    bus.ex_alu_result = 32'd70;
    bus.ex_write_data = 32'd99;
    bus.ex_dest_reg   = 5'd6;
    tick();
    check("exmem mem_write",   32'(bus.exmem_mem_write), 32'd1);
    check("exmem reg_write",   32'(bus.exmem_reg_write), 32'd0);
    check("exmem alu_result",  bus.exmem_alu_result,     32'd70);
    check("exmem write_data",  bus.exmem_write_data,     32'd99);
    check("exmem dest_reg",    32'(bus.exmem_dest_reg),  32'd6);
    check("exmem ifid held",   bus.ifid_instruction,     32'h00A6_3020);

    // Reset wins over hold.
    bus.ifid_hold = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rsthold ifid_instruction", bus.ifid_instruction, 32'd0);
    check("rsthold ifid_pc4",         bus.ifid_pc4,         32'd0);
    check("rsthold idex_read_data1",  bus.idex_read_data1,  32'd0);
    check_exmem_zero("rsthold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
